// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: registered 1-to-NUM_OUT valid/ready demultiplexer with one entry per channel.
// Define DEMUX_ERR_CNT_EN to add err_count, a saturating count of illegal-select drops.
//
// state    | meaning
// ST_EMPTY | channel holds no entry, out_valid[k] low
// ST_FULL  | channel holds an entry, out_valid[k] high
module demux_1to4_stream #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [2:0]               in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     sel_err
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} ch_state_t;

  ch_state_t          state_q [NUM_OUT];
  ch_state_t          state_d [NUM_OUT];
  logic [WIDTH-1:0]   data_q  [NUM_OUT];
  logic               sel_legal;
  logic               accept;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] drain;

  assign sel_legal = ({1'b0, in_sel} < 4'(NUM_OUT));

  // Illegal selects match no channel and are always accepted so they can be dropped.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (in_sel == 3'(k)) in_ready = !out_valid[k] || out_ready[k];
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load  = '0;
    drain = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      load[k]  = accept && sel_legal && (in_sel == 3'(k));
      drain[k] = out_valid[k] && out_ready[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OUT; k++) state_q[k] <= ST_EMPTY;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) state_q[k] <= state_d[k];
    end
  end

  // A load wins over a drain, so a channel refilled while draining stays full.
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        ST_EMPTY: if (load[k]) state_d[k] = ST_FULL;
        ST_FULL:  if (!load[k] && drain[k]) state_d[k] = ST_EMPTY;
        default:  state_d[k] = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_valid[k]                = (state_q[k] == ST_FULL);
      out_data[k*WIDTH +: WIDTH]  = data_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OUT; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (load[k]) data_q[k] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= accept && !sel_legal;
  end

`ifdef DEMUX_ERR_CNT_EN
  // Counts on the same edge that raises sel_err, holding at 8'hFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'h00;
    end else if (accept && !sel_legal && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Bench for demux_1to4_stream: directed vector table, reset/saturation sequences, random traffic vs model.
// Builds with or without DEMUX_ERR_CNT_EN.
module tb_demux_1to4_stream;
  localparam int WIDTH   = 8;
  localparam int NUM_OUT = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [WIDTH-1:0]         in_data;
  logic [2:0]               in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic                     sel_err;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0]               err_count;
`endif

  int checks   = 0;
  int failures = 0;

  demux_1to4_stream #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: what each channel holds, plus drop flag and drop count.
  logic [NUM_OUT-1:0] m_valid;
  logic [7:0]         m_data [NUM_OUT];
  logic               m_err;
  int                 m_cnt;

  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic [7:0] data;
    logic [3:0] rdy;
    logic       exp_rdy;
    logic [3:0] exp_valid;
    int         chk_ch;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_ready(input logic [2:0] sel, input logic [3:0] rdy);
    int s;
    s = int'(sel);
    if (s >= NUM_OUT) return 1'b1;
    return !m_valid[s] || rdy[s];
  endfunction

  task automatic model_reset();
    m_valid = '0;
    m_err   = 1'b0;
    m_cnt   = 0;
    for (int k = 0; k < NUM_OUT; k++) m_data[k] = 8'h00;
  endtask

  task automatic model_step(input logic v, input logic [2:0] sel, input logic [7:0] d, input logic [3:0] rdy);
    logic acc;
    acc = v && model_ready(sel, rdy);
    for (int k = 0; k < NUM_OUT; k++) begin
      if (acc && int'(sel) == k) begin
        m_valid[k] = 1'b1;
        m_data[k]  = d;
      end else if (m_valid[k] && rdy[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    m_err = acc && (int'(sel) >= NUM_OUT);
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  task automatic check_model(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
    for (int k = 0; k < NUM_OUT; k++) begin
      if (m_valid[k]) check({tag, " out_data"}, 32'(out_data[k*WIDTH +: WIDTH]), 32'(m_data[k]));
    end
    check({tag, " sel_err"}, 32'(sel_err), 32'(m_err));
`ifdef DEMUX_ERR_CNT_EN
    check({tag, " err_count"}, 32'(err_count), 32'(m_cnt));
`endif
  endtask

  // Drive one beat, check in_ready before the edge, then outputs just after it.
  task automatic cycle(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [3:0] r, input string tag);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #2;
    check({tag, " in_ready"}, 32'(in_ready), 32'(model_ready(s, r)));
    model_step(v, s, d, r);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd2, 8'hA5, 4'hF, 1'b1, 4'b0100, 2, 8'hA5, 1'b0, 0};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 2, 8'hA5, 1'b0, 0};
    vecs[2] = '{1'b1, 3'd0, 8'h5A, 4'h0, 1'b1, 4'b0001, 0, 8'h5A, 1'b0, 0};
    vecs[3] = '{1'b1, 3'd0, 8'h77, 4'h0, 1'b0, 4'b0001, 0, 8'h5A, 1'b0, 0};
    vecs[4] = '{1'b1, 3'd3, 8'h33, 4'h0, 1'b1, 4'b1001, 3, 8'h33, 1'b0, 0};
    vecs[5] = '{1'b1, 3'd1, 8'h11, 4'h0, 1'b1, 4'b1011, 1, 8'h11, 1'b0, 0};
    vecs[6] = '{1'b1, 3'd1, 8'h22, 4'h2, 1'b1, 4'b1011, 1, 8'h22, 1'b0, 0};
    vecs[7] = '{1'b1, 3'd5, 8'h3C, 4'h0, 1'b1, 4'b1011, 1, 8'h22, 1'b1, 1};
    vecs[8] = '{1'b0, 3'd5, 8'h3C, 4'h0, 1'b1, 4'b1011, 0, 8'h5A, 1'b0, 1};
    vecs[9] = '{1'b1, 3'd7, 8'h00, 4'h9, 1'b1, 4'b0010, 1, 8'h22, 1'b1, 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_data   = 8'h00;
    out_ready = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", out_data, 32'h0);
    check("reset sel_err", 32'(sel_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      in_valid  = vecs[i].v;
      in_sel    = vecs[i].sel;
      in_data   = vecs[i].data;
      out_ready = vecs[i].rdy;
      #2;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d out_data", i), 32'(out_data[vecs[i].chk_ch*WIDTH +: WIDTH]), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d sel_err", i), 32'(sel_err), 32'(vecs[i].exp_err));
`ifdef DEMUX_ERR_CNT_EN
      check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(vecs[i].exp_cnt));
`endif
    end

    // Async reset with ch1 full and sel_err high: outputs clear with no clock edge.
    in_valid  = 1'b0;
    out_ready = 4'h0;
    rst_n     = 1'b0;
    #1;
    check("async_rst out_valid", 32'(out_valid), 32'h0);
    check("async_rst sel_err", 32'(sel_err), 32'h0);
`ifdef DEMUX_ERR_CNT_EN
    check("async_rst err_count", 32'(err_count), 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 3'd0, 8'h5C, 4'h0, "first_accept");
    cycle(1'b0, 3'd0, 8'h00, 4'hF, "first_drain");

    // Long run of illegal selects drives the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 3'(4 + $urandom_range(0, 3)), 8'($urandom), 4'($urandom), "illegal_run");
    end
`ifdef DEMUX_ERR_CNT_EN
    check("err_count saturated", 32'(err_count), 32'hFF);
`endif

    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom), 3'($urandom), 8'($urandom), 4'($urandom), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
